// File: rtl/ibex_pkg.sv
// Shared types for the parametrised multiply/divide unit.
// md_op_e is the existing operator encoding; md_param_fsm_e and
// md_mul_pass_e describe the iterative multdiv control.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    localparam int unsigned MD_PARAM_STATE_W = 3;

    typedef enum logic [MD_PARAM_STATE_W-1:0] {
        MD_P_IDLE     = 3'd0,
        MD_P_MUL      = 3'd1,
        MD_P_DIV_ABS  = 3'd2,
        MD_P_DIV_ITER = 3'd3,
        MD_P_DIV_SIGN = 3'd4,
        MD_P_DONE     = 3'd5
    } md_param_fsm_e;

    // Partial-product pass: operand halves fed to the kernel multiplier
    typedef enum logic [1:0] {
        MD_PASS_LL = 2'b00,
        MD_PASS_LH = 2'b01,
        MD_PASS_HL = 2'b10,
        MD_PASS_HH = 2'b11
    } md_mul_pass_e;

    function automatic logic md_is_mul(input md_op_e op);
        return (op == MD_OP_MULL) || (op == MD_OP_MULH);
    endfunction

endpackage

// File: rtl/ibex_md_lzc.sv
// Parametrised leading-zero counter. lz_count is the number of zero bits
// above the most significant set bit; all_zero flags an all-zero input
// (lz_count is then WIDTH-1 and should be ignored).
module ibex_md_lzc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]         value,
    output logic [$clog2(WIDTH)-1:0] lz_count,
    output logic                     all_zero
);
    localparam int unsigned CW = $clog2(WIDTH);

    // Scan upward so the highest set bit determines the count
    always_comb begin
        lz_count = CW'(WIDTH - 1);
        all_zero = (value == {WIDTH{1'b0}});
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                lz_count = CW'(WIDTH - 1 - i);
            end else begin
                lz_count = lz_count;
            end
        end
    end

endmodule

// File: rtl/ibex_multdiv_param_assert.sv
// Protocol/state checker for ibex_multdiv_param.
module ibex_multdiv_param_assert
    import ibex_pkg::*;
(
    input logic                        clk,
    input logic                        rst_n,
    input logic [MD_PARAM_STATE_W-1:0] state,
    input logic                        ready,
    input logic                        valid
);

    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state inside {MD_P_IDLE, MD_P_MUL, MD_P_DIV_ABS, MD_P_DIV_ITER,
                      MD_P_DIV_SIGN, MD_P_DONE});

    a_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
        valid |=> !valid);

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ready && valid));

endmodule

// File: rtl/ibex_multdiv_param.sv
// Parametrised iterative multiply/divide unit (RV32M MUL/MULH*/DIV*/REM*)
// for any even WIDTH >= 8. Multiplication uses one (WIDTH/2+1)^2 signed
// kernel over 3-4 passes; division is restoring, one bit per cycle.
// Optional build macro IBEX_MD_DIV_EARLY_EXIT_EN: start division at the
// MSB of |a| (leading-zero count) for early termination.
module ibex_multdiv_param
    import ibex_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             kill_i,
    input  md_op_e           operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned AW = WIDTH + 2;
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    md_param_fsm_e            state_r, state_s;
    md_op_e                   op_r;
    logic [1:0]               smode_r;
    logic [WIDTH-1:0]         a_r, b_r;
    logic signed [AW-1:0]     acc_r;
    logic [H-1:0]             lo_r;
    md_mul_pass_e             pass_r;
    logic [WIDTH-1:0]         num_r, den_r, rem_r, quo_r, result_r;
    logic [CW-1:0]            cnt_r;
    logic                     neg_q_r, neg_r_r;

    logic                     accept_s;
    logic                     sign_a_s, sign_b_s, b_zero_s;
    logic [WIDTH-1:0]         abs_a_s, abs_b_s;
    logic [H:0]               kx_s, ky_s;
    logic signed [AW-1:0]     kx_ext_s, ky_ext_s, kprod_s, mac_s;
    logic [WIDTH:0]           rem_shift_s;
    logic [WIDTH+1:0]         trial_s;
    logic                     trial_ge_s;

`ifdef IBEX_MD_DIV_EARLY_EXIT_EN
    logic [CW-1:0]            lz_cnt_s;
    logic                     a_zero_s;

    ibex_md_lzc #(.WIDTH(WIDTH)) u_lzc (
        .value    (abs_a_s),
        .lz_count (lz_cnt_s),
        .all_zero (a_zero_s)
    );
`endif

    // Operand conditioning, kernel multiplier and trial subtractor
    always_comb begin
        accept_s = (state_r == MD_P_IDLE) && req_i && !kill_i;
        sign_a_s = smode_r[0] & a_r[WIDTH-1];
        sign_b_s = smode_r[1] & b_r[WIDTH-1];
        abs_a_s  = sign_a_s ? neg_w(a_r) : a_r;
        abs_b_s  = sign_b_s ? neg_w(b_r) : b_r;
        b_zero_s = (b_r == {WIDTH{1'b0}});

        case (pass_r)
            MD_PASS_LL: begin kx_s = {1'b0, a_r[H-1:0]};             ky_s = {1'b0, b_r[H-1:0]};             end
            MD_PASS_LH: begin kx_s = {1'b0, a_r[H-1:0]};             ky_s = {sign_b_s, b_r[WIDTH-1:H]};     end
            MD_PASS_HL: begin kx_s = {sign_a_s, a_r[WIDTH-1:H]};     ky_s = {1'b0, b_r[H-1:0]};             end
            MD_PASS_HH: begin kx_s = {sign_a_s, a_r[WIDTH-1:H]};     ky_s = {sign_b_s, b_r[WIDTH-1:H]};     end
            default:    begin kx_s = {1'b0, a_r[H-1:0]};             ky_s = {1'b0, b_r[H-1:0]};             end
        endcase
        kx_ext_s = {{(AW-H-1){kx_s[H]}}, kx_s};
        ky_ext_s = {{(AW-H-1){ky_s[H]}}, ky_s};
        kprod_s  = kx_ext_s * ky_ext_s;
        mac_s    = acc_r + kprod_s;

        rem_shift_s = {rem_r, num_r[cnt_r]};
        trial_s     = {1'b0, rem_shift_s} - {2'b00, den_r};
        trial_ge_s  = ~trial_s[WIDTH+1];
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= MD_P_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; kill_i returns to IDLE from anywhere
    always_comb begin
        state_s = state_r;
        case (state_r)
            MD_P_IDLE: begin
                if (accept_s) begin
                    state_s = md_is_mul(operator_i) ? MD_P_MUL : MD_P_DIV_ABS;
                end else begin
                    state_s = MD_P_IDLE;
                end
            end
            MD_P_MUL: begin
                if ((pass_r == MD_PASS_HH) ||
                    ((pass_r == MD_PASS_HL) && (op_r == MD_OP_MULL))) begin
                    state_s = MD_P_DONE;
                end else begin
                    state_s = MD_P_MUL;
                end
            end
            MD_P_DIV_ABS: begin
                if (b_zero_s) begin
                    state_s = MD_P_DONE;
`ifdef IBEX_MD_DIV_EARLY_EXIT_EN
                end else if (a_zero_s) begin
                    state_s = MD_P_DIV_SIGN;
`endif
                end else begin
                    state_s = MD_P_DIV_ITER;
                end
            end
            MD_P_DIV_ITER: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = MD_P_DIV_SIGN;
                end else begin
                    state_s = MD_P_DIV_ITER;
                end
            end
            MD_P_DIV_SIGN: state_s = MD_P_DONE;
            MD_P_DONE:     state_s = MD_P_IDLE;
            default:       state_s = MD_P_IDLE;
        endcase
        if (kill_i) begin
            state_s = MD_P_IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // FSM outputs: decode of the state register, valid suppressed by kill
    always_comb begin
        ready_o  = (state_r == MD_P_IDLE);
        valid_o  = (state_r == MD_P_DONE) && !kill_i;
        result_o = result_r;
    end

    // Datapath registers: operand capture, multiply passes, division steps
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_r     <= MD_OP_MULL;
            smode_r  <= 2'b00;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            acc_r    <= {AW{1'b0}};
            lo_r     <= {H{1'b0}};
            pass_r   <= MD_PASS_LL;
            num_r    <= {WIDTH{1'b0}};
            den_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                MD_P_IDLE: begin
                    if (accept_s) begin
                        op_r    <= operator_i;
                        smode_r <= signed_mode_i;
                        a_r     <= op_a_i;
                        b_r     <= op_b_i;
                        acc_r   <= {AW{1'b0}};
                        pass_r  <= MD_PASS_LL;
                    end
                end
                MD_P_MUL: begin
                    case (pass_r)
                        MD_PASS_LL: begin
                            acc_r  <= mac_s >>> H;
                            lo_r   <= mac_s[H-1:0];
                            pass_r <= MD_PASS_LH;
                        end
                        MD_PASS_LH: begin
                            acc_r  <= mac_s;
                            pass_r <= MD_PASS_HL;
                        end
                        MD_PASS_HL: begin
                            acc_r  <= mac_s >>> H;
                            pass_r <= MD_PASS_HH;
                            if (op_r == MD_OP_MULL) begin
                                result_r <= {mac_s[H-1:0], lo_r};
                            end
                        end
                        MD_PASS_HH: begin
                            result_r <= mac_s[WIDTH-1:0];
                            pass_r   <= MD_PASS_LL;
                        end
                        default: pass_r <= MD_PASS_LL;
                    endcase
                end
                MD_P_DIV_ABS: begin
                    num_r   <= abs_a_s;
                    den_r   <= abs_b_s;
                    rem_r   <= {WIDTH{1'b0}};
                    quo_r   <= {WIDTH{1'b0}};
                    neg_q_r <= sign_a_s ^ sign_b_s;
                    neg_r_r <= sign_a_s;
`ifdef IBEX_MD_DIV_EARLY_EXIT_EN
                    cnt_r   <= CNT_MAX - lz_cnt_s;
`else
                    cnt_r   <= CNT_MAX;
`endif
                    if (b_zero_s) begin
                        result_r <= (op_r == MD_OP_DIV) ? {WIDTH{1'b1}} : a_r;
                    end
                end
                MD_P_DIV_ITER: begin
                    if (trial_ge_s) begin
                        rem_r        <= trial_s[WIDTH-1:0];
                        quo_r[cnt_r] <= 1'b1;
                    end else begin
                        rem_r <= rem_shift_s[WIDTH-1:0];
                    end
                    cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
                MD_P_DIV_SIGN: begin
                    if (op_r == MD_OP_DIV) begin
                        result_r <= neg_q_r ? neg_w(quo_r) : quo_r;
                    end else begin
                        result_r <= neg_r_r ? neg_w(rem_r) : rem_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    ibex_multdiv_param_assert u_assert (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .state (state_r),
        .ready (ready_o),
        .valid (valid_o)
    );

endmodule

// File: tb/tb_ibex_multdiv_param.sv
// Scoreboard bench for ibex_multdiv_param (WIDTH=32): expected result and
// due cycle are queued at acceptance, a monitor compares on valid_o.
module tb_ibex_multdiv_param;
    import ibex_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req, kill;
    md_op_e       op;
    logic [1:0]   sm;
    logic [W-1:0] a, b;
    logic         ready, valid;
    logic [W-1:0] result;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        int           due;
        string        name;
    } exp_t;
    exp_t sb[$];

    ibex_multdiv_param #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .kill_i        (kill),
        .operator_i    (op),
        .signed_mode_i (sm),
        .op_a_i        (a),
        .op_b_i        (b),
        .ready_o       (ready),
        .valid_o       (valid),
        .result_o      (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on sign/zero-extended operands
    function automatic logic [W-1:0] model(md_op_e o, logic [1:0] s, logic [W-1:0] x, logic [W-1:0] y);
        logic signed [65:0] ex, ey, p;
        logic signed [33:0] dx, dy, qq, rr;
        ex = s[0] ? {{34{x[W-1]}}, x} : {34'd0, x};
        ey = s[1] ? {{34{y[W-1]}}, y} : {34'd0, y};
        p  = ex * ey;
        dx = s[0] ? {{2{x[W-1]}}, x} : {2'b00, x};
        dy = s[1] ? {{2{y[W-1]}}, y} : {2'b00, y};
        case (o)
            MD_OP_MULL: return p[31:0];
            MD_OP_MULH: return p[63:32];
            default: begin
                if (y == 32'd0) return (o == MD_OP_DIV) ? 32'hFFFF_FFFF : x;
                qq = dx / dy;
                rr = dx % dy;
                return (o == MD_OP_DIV) ? qq[31:0] : rr[31:0];
            end
        endcase
    endfunction

    function automatic int latency(md_op_e o, logic [1:0] s, logic [W-1:0] x, logic [W-1:0] y);
`ifdef IBEX_MD_DIV_EARLY_EXIT_EN
        logic signed [33:0] dx;
        logic [33:0] mag;
        int msb;
`endif
        if (o == MD_OP_MULL) return 4;
        if (o == MD_OP_MULH) return 5;
        if (y == 32'd0) return 2;
`ifdef IBEX_MD_DIV_EARLY_EXIT_EN
        dx  = s[0] ? {{2{x[W-1]}}, x} : {2'b00, x};
        mag = (dx < 0) ? -dx : dx;
        if (mag == 34'd0) return 3;
        msb = 0;
        for (int i = 0; i < 34; i++) if (mag[i]) msb = i;
        return msb + 4;
`else
        return W + 3;
`endif
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on each valid, flag spurious/late/overlap
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid) begin
                checks++;
                if (ready) begin
                    errors++;
                    $display("FAIL ready_valid_overlap cycle=%0d", cyc);
                end
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_valid result=%h cycle=%0d", result, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    if (result !== e.res) begin
                        errors++;
                        $display("FAIL %s result actual=%h expected=%h", e.name, result, e.res);
                    end
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL %s latency actual_cycle=%0d expected_cycle=%0d", e.name, cyc, e.due);
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL %s timeout expected_cycle=%0d now=%0d", sb[0].name, sb[0].due, cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(md_op_e o, logic [1:0] s, logic [W-1:0] x, logic [W-1:0] y,
                         string nm, bit track, output int t);
        int budget;
        exp_t e;
        budget = 0;
        @(negedge clk);
        while (!ready && budget < 200) begin
            budget++;
            @(negedge clk);
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL %s ready_timeout actual=0 expected=1", nm);
        end
        req = 1'b1; op = o; sm = s; a = x; b = y;
        t = cyc;
        if (track) begin
            e.res  = model(o, s, x, y);
            e.due  = t + latency(o, s, x, y);
            e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
        a = $urandom;
        b = $urandom;
        op = md_op_e'($urandom_range(0, 3));
        sm = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() > 0 && budget < 200) begin
            budget++;
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t;
        rst_n = 1'b0; req = 1'b0; kill = 1'b0;
        op = MD_OP_MULL; sm = 2'b00; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;

        issue(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, "mulh_minmin", 1'b1, t); drain();
        issue(MD_OP_MULL, 2'b11, 32'h8000_0000, 32'h8000_0000, "mull_minmin", 1'b1, t); drain();
        issue(MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1, t); drain();
        issue(MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b1, t); drain();
        issue(MD_OP_DIV,  2'b00, 32'h0000_1234, 32'h0000_0000, "divu_by0", 1'b1, t); drain();
        issue(MD_OP_REM,  2'b00, 32'h0000_1234, 32'h0000_0000, "remu_by0", 1'b1, t); drain();
        issue(MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, "rem_neg7", 1'b1, t); drain();
        issue(MD_OP_DIV,  2'b00, 32'h0000_0005, 32'h0000_0002, "divu_5_2", 1'b1, t); drain();
        issue(MD_OP_DIV,  2'b11, 32'h0000_0000, 32'h0000_0007, "div_zero_a", 1'b1, t); drain();

        // Kill an in-flight division at T+10
        issue(MD_OP_DIV, 2'b11, 32'h1234_5678, 32'h0000_0013, "div_killed", 1'b0, t);
        while (cyc < t + 10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_ready_next", {31'd0, ready}, 32'd1);
        issue(MD_OP_MULL, 2'b00, 32'd3, 32'd5, "mull_after_kill", 1'b1, t); drain();

        // Reset during the HL pass of a multiply
        issue(MD_OP_MULL, 2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D, "mull_reset", 1'b1, t);
        while (cyc < t + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, ready}, 32'd1);
        chk("rst_mid_valid", {31'd0, valid}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(MD_OP_MULH, 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, "mulhsu_after_rst", 1'b1, t); drain();

        // Randomised operations
        for (int n = 0; n < 150; n++) begin
            md_op_e ro;
            logic [1:0] rs;
            ro = md_op_e'($urandom_range(0, 3));
            rs = 2'($urandom_range(0, 3));
            issue(ro, rs, pick(), pick(), $sformatf("rand%0d_op%0d_sm%0d", n, ro, rs), 1'b1, t);
            drain();
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_multdiv_param.md
# ibex_multdiv_param

Parametrised, self-contained multiply/divide unit for the Ibex execute stage, succeeding the fixed 32-bit fast multdiv. It implements RISC-V M-extension MUL/MULH(SU/U)/DIV(U)/REM(U) for any even operand width. It owns its subtractor and uses a req/ready/valid handshake with kill instead of borrowing the ALU adder, and it optionally skips leading zeros of the dividend for early division termination.

## Interface
- WIDTH, 32, operand/result width; even, ≥ 8; kernel multiplier is (WIDTH/2+1)x(WIDTH/2+1) signed
- clk_i  input  1  clock
- rst_ni  input  1  reset: asynchronous, active-low
- req_i  input  1  operation request; accepted when req_i & ready_o & ~kill_i
- kill_i  input  1  abort in-flight operation (flush); dominates all other inputs
- operator_i  input  md_op_e  MD_OP_MULL / MD_OP_MULH / MD_OP_DIV / MD_OP_REM
- signed_mode_i  input  2  bit0: op_a signed, bit1: op_b signed
- op_a_i, op_b_i  input  WIDTH  operands; sampled only at acceptance
- ready_o  input-facing output  1  high iff FSM in IDLE
- valid_o  output  1  one-cycle result strobe
- result_o  output  WIDTH  result; stable only while valid_o high

## Operation
- Acceptance cycle T: operator, signed mode and operands captured into internal registers; inputs are don't-care afterwards.
- FSM states: IDLE, MUL, DIV_ABS, DIV_ITER, DIV_SIGN, DONE. Encoding lives in the package, 3 bits.
- MUL: pass sequence LL, LH, HL, then HH for MULH only, one pass per cycle. Passes accumulate into a WIDTH+2-bit signed accumulator with the same carry/sign rules as the fast kernel. MULL takes low WIDTH bits; MULH takes high WIDTH bits of the 2*WIDTH product. MUL→DONE after last pass.
- DIV_ABS, 1 cycle: |a|, |b| computed per signed mode.
  - b==0: result = all ones for DIV, a for REM; go to DONE.
  - Otherwise: remainder=0, quotient=0, counter=WIDTH-1; go to DIV_ITER.
- DIV_ITER: restoring division, 1 bit per cycle.
  - rem' = {rem,num[cnt]}.
  - If rem' ≥ |b|: rem' -= |b| and q[cnt]=1.
  - Counter decrements; at cnt==0 go to DIV_SIGN.
- DIV_SIGN, 1 cycle: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a); go to DONE.
- Signed overflow (most-negative / -1) falls out naturally: quotient = most-negative, remainder = 0.
- DONE: valid_o=1, result_o = final value; next state IDLE unconditionally. There is no back-pressure; the consumer must take the result.
- kill_i in any non-IDLE state: next state IDLE, valid_o forced 0 that cycle, internal registers don't-care.
- kill_i with req_i in IDLE: request not accepted.
- Unused and illegal FSM encodings go to IDLE.

## Timing
- Reset values: state IDLE, ready_o=1, valid_o=0, result_o=0, all internal registers 0.
- valid_o is registered state decode gated by ~kill_i. result_o is a direct register output.
- Latency, acceptance at T:
  - MULL: valid_o at T+4.
  - MULH: valid_o at T+5.
  - DIV/REM with b==0: valid_o at T+2.
  - DIV/REM general: valid_o at T+WIDTH+3.
- ready_o returns high the cycle after DONE (T+latency+1). The earliest back-to-back acceptance is at that cycle.
- Reset asserted mid-operation: immediate return to IDLE, outputs at reset values, no valid_o.

## Configuration
- IBEX_MD_DIV_EARLY_EXIT_EN defined:
  - DIV_ABS loads counter = index of MSB of |a|, computed by leading-zero count.
  - |a|==0 with b≠0: skip DIV_ITER, go straight to DIV_SIGN.
  - General latency: T+(msb_idx+1)+3. |a|==0: T+3.
- Macro undefined: the fixed WIDTH iterations above, and the leading-zero counter is not instantiated.
- Results are identical in both builds.

## Structure
- ibex_pkg: md_op_e (existing), new md_param_fsm_e, and the constant MD_PARAM_STATE_W=3.
- Sub-module ibex_md_lzc: parametrised leading-zero counter, WIDTH in, $clog2(WIDTH) out plus an all_zero flag. Instantiated only under IBEX_MD_DIV_EARLY_EXIT_EN.
- Assertions:
  - state always inside the legal set;
  - valid_o never high in two consecutive cycles;
  - ready_o and valid_o never high together.

## Test plan
- WIDTH=32, MULH, signed_mode=11, a=0x80000000, b=0x80000000 → valid_o at T+5, result 0x40000000. MULL with the same operands → result 0x00000000 at T+4.
- WIDTH=32, DIV, signed_mode=11, a=0x80000000, b=0xFFFFFFFF → result 0x80000000; REM with the same operands → 0x00000000; both at T+35 without the macro.
- DIVU b=0, a=0x1234 → 0xFFFFFFFF at T+2; REMU with the same operands → 0x00001234.
- WIDTH=16, REM, signed_mode=11, a=-7 (0xFFF9), b=2 → 0xFFFF. With IBEX_MD_DIV_EARLY_EXIT_EN and DIVU a=5, b=2 → result 2 at T+6.
- Issue DIV, assert kill_i at T+10 → no valid_o, ready_o high at T+11. Next request MULL 3*5 → result 15 at its T+4.
- rst_ni pulsed low during MUL pass HL → ready_o=1, valid_o=0, result_o=0 immediately. No stale valid_o after release.
